// File: rtl/nco_pkg.sv
// Shared types for the NCO tone sequencer: FSM states, queued tone entries
// and the NCO control word width.
package nco_pkg;

  localparam int NCO_CTRL_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [NCO_CTRL_W-1:0] control;
    logic [15:0]           duration;
  } tone_entry_t;

endpackage

// File: rtl/nco_tone_fifo.sv
// First-word-fall-through queue of tone entries; head always shows the
// oldest entry and pop simply advances past it.
module nco_tone_fifo
  import nco_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  tone_entry_t            push_data,
  input  logic                   pop,
  input  logic                   flush,
  output tone_entry_t            head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  tone_entry_t     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/nco_tone_sequencer.sv
// Plays queued tones on the NCO: each entry's control word is held for
// duration * TICK_DIV cycles, with the NCO held in reset whenever idle.
module nco_tone_sequencer
  import nco_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int TICK_DIV = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [NCO_CTRL_W-1:0]  s_control,
  input  logic [15:0]            s_duration,
  input  logic                   start,
  input  logic                   abort,
  output logic [NCO_CTRL_W-1:0]  nco_control,
  output logic                   nco_reset,
  output logic                   busy,
  output logic                   tone_done,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  seq_state_t            state_q, state_d;
  logic [NCO_CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [15:0]           unit_q, unit_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic                  nco_reset_q, nco_reset_d;
  logic                  tone_done_q, tone_done_d;

  tone_entry_t           head;
  logic                  fifo_full, fifo_empty;
  logic                  push, pop;
  logic [CW-1:0]         count;

  assign s_ready = !fifo_full && !abort;
  assign push    = s_valid && s_ready;

  nco_tone_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({s_control, s_duration}),
    .pop       (pop),
    .flush     (abort),
    .head      (head),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    unit_d      = unit_q;
    tick_d      = tick_q;
    nco_reset_d = nco_reset_q;
    tone_done_d = 1'b0;
    pop         = 1'b0;

    if (abort) begin
      state_d     = IDLE;
      nco_reset_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !fifo_empty) state_d = LOAD;
        end
        LOAD: begin
          pop = 1'b1;
          if (head.duration != 16'd0) begin
            ctrl_d      = head.control;
            unit_d      = head.duration;
            tick_d      = '0;
            nco_reset_d = 1'b0;
            state_d     = PLAY;
          end else begin
            // Skipped entry: continue only if something remains after this pop.
            tone_done_d = 1'b1;
            if ((count > CW'(1)) || push) begin
              state_d = LOAD;
            end else begin
              state_d     = IDLE;
              nco_reset_d = 1'b1;
            end
          end
        end
        PLAY: begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (unit_q == 16'd1) begin
              tone_done_d = 1'b1;
              // nco_reset stays low into LOAD so the phase runs on.
              if ((count != '0) || push) begin
                state_d = LOAD;
              end else begin
                state_d     = IDLE;
                nco_reset_d = 1'b1;
              end
            end else begin
              unit_d = unit_q - 16'd1;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        default: begin
          state_d     = IDLE;
          nco_reset_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ctrl_q      <= '0;
      unit_q      <= '0;
      tick_q      <= '0;
      nco_reset_q <= 1'b1;
      tone_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      unit_q      <= unit_d;
      tick_q      <= tick_d;
      nco_reset_q <= nco_reset_d;
      tone_done_q <= tone_done_d;
    end
  end

  assign nco_control = ctrl_q;
  assign nco_reset   = nco_reset_q;
  assign busy        = (state_q != IDLE);
  assign tone_done   = tone_done_q;
  assign fifo_count  = count;

endmodule

// File: tb/tb_nco_tone_sequencer.sv
// Directed bench for nco_tone_sequencer with TICK_DIV = 4 and DEPTH = 4.
module tb_nco_tone_sequencer;

  localparam int DEPTH    = 4;
  localparam int TICK_DIV = 4;

  logic        clk;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_control;
  logic [15:0] s_duration;
  logic        start;
  logic        abort;
  logic [15:0] nco_control;
  logic        nco_reset;
  logic        busy;
  logic        tone_done;
  logic [2:0]  fifo_count;

  int checks     = 0;
  int passes     = 0;
  int done_total = 0;
  int d0;

  nco_tone_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_control   (s_control),
    .s_duration  (s_duration),
    .start       (start),
    .abort       (abort),
    .nco_control (nco_control),
    .nco_reset   (nco_reset),
    .busy        (busy),
    .tone_done   (tone_done),
    .fifo_count  (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (tone_done === 1'b1) done_total++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] c, input logic [15:0] d);
    s_valid    = 1'b1;
    s_control  = c;
    s_duration = d;
    tick();
    s_valid    = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One comparison per cycle on {nco_control, nco_reset, busy}.
  task automatic expect_cycles(input string tag, input int n, input logic [15:0] c,
                               input logic r, input logic b);
    for (int i = 0; i < n; i++) begin
      check(tag, {nco_control, nco_reset, busy}, {c, r, b});
      tick();
    end
  endtask

  task automatic check_reset_state(input string tag);
    check(tag, {nco_control, nco_reset, busy, tone_done, fifo_count, s_ready},
          {16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1});
  endtask

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_control = '0; s_duration = '0;
    start = 1'b0; abort = 1'b0;
    tick(); tick();
    check_reset_state("in reset");
    reset = 1'b0;
    check_reset_state("after reset");

    // Single tone {0x0010, 3}: 12 PLAY cycles.
    push(16'h0010, 16'd3);
    check("t1 count", fifo_count, 1);
    d0 = done_total;
    pulse_start();
    expect_cycles("t1 load", 1, 16'h0000, 1'b1, 1'b1);
    expect_cycles("t1 play", 12, 16'h0010, 1'b0, 1'b1);
    check("t1 done", tone_done, 1);
    expect_cycles("t1 idle", 1, 16'h0010, 1'b1, 1'b0);
    check("t1 pulses", done_total - d0, 1);
    check("t1 count end", fifo_count, 0);

    // Back-to-back tones with continuous nco_reset low.
    push(16'h0005, 16'd1);
    push(16'h0009, 16'd2);
    d0 = done_total;
    pulse_start();
    expect_cycles("t2 load1", 1, 16'h0010, 1'b1, 1'b1);
    expect_cycles("t2 play1", 4, 16'h0005, 1'b0, 1'b1);
    check("t2 done1", tone_done, 1);
    expect_cycles("t2 load2", 1, 16'h0005, 1'b0, 1'b1);
    expect_cycles("t2 play2", 8, 16'h0009, 1'b0, 1'b1);
    check("t2 done2", tone_done, 1);
    expect_cycles("t2 idle", 1, 16'h0009, 1'b1, 1'b0);
    check("t2 pulses", done_total - d0, 2);

    // Full queue: 5th entry stalls until the first pop.
    d0 = done_total;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_control = 16'h0100 + 16'(i); s_duration = 16'd1;
      tick();
    end
    s_control = 16'h0104;
    check("t3 full ready", s_ready, 0);
    check("t3 full count", fifo_count, 4);
    pulse_start();
    check("t3 load ready", s_ready, 0);
    expect_cycles("t3 load0", 1, 16'h0009, 1'b1, 1'b1);
    check("t3 ready after pop", s_ready, 1);
    check("t3 count after pop", fifo_count, 3);
    expect_cycles("t3 play0", 1, 16'h0100, 1'b0, 1'b1);
    s_valid = 1'b0;
    check("t3 count refill", fifo_count, 4);
    expect_cycles("t3 play0", 3, 16'h0100, 1'b0, 1'b1);
    for (int i = 1; i < 5; i++) begin
      expect_cycles("t3 load", 1, 16'h0100 + 16'(i - 1), 1'b0, 1'b1);
      expect_cycles("t3 play", 4, 16'h0100 + 16'(i), 1'b0, 1'b1);
    end
    expect_cycles("t3 idle", 1, 16'h0104, 1'b1, 1'b0);
    check("t3 pulses", done_total - d0, 5);

    // Zero-duration entry is skipped.
    push(16'h0020, 16'd0);
    push(16'h0030, 16'd1);
    d0 = done_total;
    pulse_start();
    expect_cycles("t4 skip load", 1, 16'h0104, 1'b1, 1'b1);
    check("t4 skip done", tone_done, 1);
    expect_cycles("t4 load", 1, 16'h0104, 1'b1, 1'b1);
    expect_cycles("t4 play", 4, 16'h0030, 1'b0, 1'b1);
    expect_cycles("t4 idle", 1, 16'h0030, 1'b1, 1'b0);
    check("t4 pulses", done_total - d0, 2);

    // Abort on the 2nd PLAY cycle with a push offered.
    push(16'h0040, 16'd2);
    push(16'h0041, 16'd2);
    push(16'h0042, 16'd2);
    d0 = done_total;
    pulse_start();
    tick();
    check("t5 play1", {nco_control, nco_reset}, {16'h0040, 1'b0});
    tick();
    abort = 1'b1; s_valid = 1'b1; s_control = 16'h0077; s_duration = 16'd1;
    #1;
    check("t5 abort ready", s_ready, 0);
    tick();
    abort = 1'b0; s_valid = 1'b0;
    check("t5 after abort", {nco_control, nco_reset, busy, fifo_count, tone_done},
          {16'h0040, 1'b1, 1'b0, 3'd0, 1'b0});
    pulse_start();
    check("t5 start ignored", {busy, fifo_count}, {1'b0, 3'd0});
    tick();
    check("t5 still idle", {busy, nco_reset}, {1'b0, 1'b1});
    check("t5 pulses", done_total - d0, 0);

    // Start on empty queue, then reset mid-PLAY.
    pulse_start();
    check("t6 empty start", {busy, nco_reset}, {1'b0, 1'b1});
    push(16'h0055, 16'd5);
    pulse_start();
    tick();
    check("t6 playing", {nco_control, nco_reset, busy}, {16'h0055, 1'b0, 1'b1});
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("t6 reset mid play");
    tick();
    check_reset_state("t6 reset stays idle");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/nco_tone_sequencer.md
# nco_tone_sequencer

Controller that sequences the numerically controlled oscillator through a queued list of tones. Each queued entry is a frequency control word plus a play duration. The sequencer buffers up to DEPTH entries and, once started, drives the NCO control word and reset so that each tone plays for exactly its duration. It sits between a register/host front end and the NCO, and owns the NCO's `control` and `reset` inputs.

## Interface
- DEPTH, 4: tone queue depth in entries; power of two, at least 2.
- TICK_DIV, 1024: clk cycles per duration unit; at least 1.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- s_valid  in  1  host offers a tone entry.
- s_ready  out  1  queue accepts the entry this cycle.
- s_control  in  16  NCO frequency control word for the entry.
- s_duration  in  16  play time in duration units.
- start  in  1  single-cycle request to begin playback.
- abort  in  1  stop playback and flush the queue.
- nco_control  out  16  drives NCO `control`.
- nco_reset  out  1  drives NCO `reset`; high while idle, so the NCO phase and amplitude are held at 0.
- busy  out  1  high in LOAD and PLAY.
- tone_done  out  1  one-cycle pulse per completed or skipped entry.
- fifo_count  out  $clog2(DEPTH)+1  number of queued entries.

## Operation
- Reset values: state IDLE, queue empty, fifo_count 0, nco_control 0, nco_reset 1, busy 0, tone_done 0. s_ready is 1 in the first cycle after reset deasserts.
- Push:
  - s_ready = (fifo_count < DEPTH) && !abort.
  - An entry is accepted at a clock edge where s_valid && s_ready.
  - Pushes are allowed in every state.
  - A push and a pop in the same cycle leave fifo_count unchanged.
- State machine has three states: IDLE, LOAD, PLAY.
- IDLE:
  - nco_reset is 1.
  - If start is high and fifo_count > 0, go to LOAD.
  - If start is high with an empty queue, it is ignored.
  - start outside IDLE is ignored.
- LOAD (1 cycle):
  - Pop the head entry.
  - If its duration is nonzero, latch control into nco_control, load the tick and unit counters, and go to PLAY.
  - If its duration is 0, the entry is skipped: nco_control is unchanged, tone_done pulses next cycle, and the next state follows the end-of-tone rule below.
- PLAY:
  - nco_reset is 0.
  - The counters run for exactly duration × TICK_DIV cycles.
  - On the last PLAY cycle, the next state is LOAD if fifo_count > 0 (counting a push accepted that same cycle); otherwise it is IDLE.
  - The same rule applies after a skip in LOAD.
- Back-to-back tones:
  - nco_reset stays 0 through the intervening LOAD cycle.
  - nco_control holds the previous word during LOAD, so the NCO phase is continuous across the tone change.
- Returning to IDLE: nco_reset is 1 from the first IDLE cycle. nco_control keeps its last value.
- abort:
  - Has priority over every other event, in any state.
  - The next state is IDLE and the queue is flushed (fifo_count 0 next cycle).
  - A push offered in the abort cycle is dropped (s_ready is 0).
  - No tone_done pulse is produced for the interrupted tone.
- Counter widths:
  - Tick counter: $clog2(TICK_DIV) bits.
  - Unit counter: 16 bits, counting down from duration to 1.
  - No overflow is possible; maximum tone length is 65535 × TICK_DIV cycles.

## Timing
- Start latency:
  - start is high in cycle 0, in IDLE with a non-empty queue.
  - Cycle 1 is LOAD.
  - From cycle 2 the state is PLAY, nco_control equals the entry's control word, nco_reset is 0 and busy is 1.
- busy:
  - Goes to 1 in cycle 1 (LOAD).
  - Goes to 0 in the first IDLE cycle.
- tone_done: registered; high in the cycle after the last PLAY cycle of a tone, or the cycle after LOAD for a skipped entry.
- Tone N+1 PLAY begins 2 cycles after the last PLAY cycle of tone N (one LOAD cycle in between).
- fifo_count:
  - Changes the cycle after an accepted push.
  - Changes the cycle after the LOAD pop.
- Reset mid-operation behaves exactly as the reset state; queue contents are lost.

## Structure
- Shared package nco_pkg holds:
  - the state enum seq_state_t (IDLE, LOAD, PLAY);
  - the struct tone_entry_t {control[15:0], duration[15:0]};
  - the constant NCO_CTRL_W = 16.
- One sub-module, nco_tone_fifo:
  - synchronous FIFO of tone_entry_t, DEPTH deep;
  - ports: push, pop, flush, head, count, full, empty;
  - pop is first-word-fall-through.
- The FSM and the tick/unit counters live in the top module.

## Test plan
Bench parameters: TICK_DIV = 4, DEPTH = 4.
- Single tone: push {0x0010, 3}, then start → nco_control = 0x0010 and nco_reset = 0 for exactly 12 cycles from cycle 2; then IDLE with nco_reset = 1; one tone_done pulse; busy low.
- Back-to-back tones: push {0x0005, 1}, {0x0009, 2}, then start → PLAY 4 cycles, 1 LOAD cycle, PLAY 8 cycles; nco_reset never rises between the tones; two tone_done pulses.
- Full queue: push 5 entries back to back → s_ready is low after the 4th accept, fifo_count = 4, and the 5th entry is stalled and not lost. It is accepted the cycle after the first LOAD pop.
- Zero duration: queue {0x0020, 0}, {0x0030, 1} → first entry is skipped with a tone_done pulse and nco_control never shows 0x0020; second entry plays for 4 cycles.
- Abort mid-tone: 3 entries queued, abort on the 2nd PLAY cycle → IDLE next cycle, nco_reset = 1, fifo_count = 0, no tone_done; start afterwards is ignored.
- Start on an empty queue and reset mid-PLAY: start does nothing; reset returns every output to its reset value the next cycle.
